// File: rtl/ex_div_pkg.sv
// Shared constants for the RV32M divider: state encoding, handshake levels,
// datapath width and the ALU op codes that select the divider.
package ex_div_pkg;

  localparam int REG_BUS = 32;

  typedef enum logic [1:0] {
    ST_FREE    = 2'b00,
    ST_BY_ZERO = 2'b01,
    ST_ON      = 2'b10,
    ST_END     = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;
  localparam logic [7:0] EXE_REM_OP  = 8'b0001_1100;
  localparam logic [7:0] EXE_REMU_OP = 8'b0001_1101;

endpackage

// File: rtl/ex_div.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU. Operates on operand
// magnitudes and sign-corrects on the final step; divide-by-zero bypasses the
// iteration and returns the RISC-V defined result.
//
// state   | meaning
// --------+----------------------------------------------------------
// FREE    | idle, outputs cleared, waiting for start_i
// BY_ZERO | divisor was zero, load all-ones quotient / raw dividend
// ON      | one restoring step per cycle, XLEN steps total
// END     | results valid (ready_o=1), held until start_i drops
module ex_div
  import ex_div_pkg::*;
#(
  parameter int XLEN = REG_BUS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            annul_i,
  input  logic            signed_div_i,
  input  logic [XLEN-1:0] opdata1_i,
  input  logic [XLEN-1:0] opdata2_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            ready_o
);

  localparam int CNT_W = $clog2(XLEN);

  div_state_e       r_state;
  div_state_e       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_div;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_accept;
  logic             w_div_zero;
  logic             w_op1_neg;
  logic             w_op2_neg;
  logic [XLEN-1:0]  w_op1_abs;
  logic [XLEN-1:0]  w_op2_abs;
  logic [XLEN:0]    w_rem_sh;
  logic             w_ge;
  logic [XLEN-1:0]  w_diff;
  logic [XLEN-1:0]  w_rem_next;
  logic [XLEN-1:0]  w_quo_next;
  logic             w_last;

  assign w_accept   = start_i && !annul_i;
  assign w_div_zero = (opdata2_i == '0);
  assign w_op1_neg  = signed_div_i && opdata1_i[XLEN-1];
  assign w_op2_neg  = signed_div_i && opdata2_i[XLEN-1];
  assign w_op1_abs  = w_op1_neg ? -opdata1_i : opdata1_i;
  assign w_op2_abs  = w_op2_neg ? -opdata2_i : opdata2_i;

  // Trial subtraction on the shifted partial remainder. The remainder is
  // always below the divisor, so the shifted value fits in XLEN+1 bits and a
  // successful difference fits back in XLEN bits.
  assign w_rem_sh   = {r_rem, r_quo[XLEN-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_div});
  assign w_diff     = w_rem_sh[XLEN-1:0] - r_div;
  assign w_rem_next = w_ge ? w_diff : w_rem_sh[XLEN-1:0];
  assign w_quo_next = {r_quo[XLEN-2:0], w_ge};
  assign w_last     = (r_cnt == CNT_W'(XLEN - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FREE;
    else     r_state <= w_state_next;
  end

  // Next-state decode; annul wins over start in every busy state.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_FREE:    if (w_accept) w_state_next = w_div_zero ? ST_BY_ZERO : ST_ON;
      ST_BY_ZERO: w_state_next = annul_i ? ST_FREE : ST_END;
      ST_ON:      if (annul_i) w_state_next = ST_FREE;
                  else if (w_last) w_state_next = ST_END;
      ST_END:     if (annul_i || !start_i) w_state_next = ST_FREE;
      default:    w_state_next = ST_FREE;
    endcase
  end

  // Operand capture, iteration datapath and registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
      ready_o     <= DivResultNotReady;
    end else begin
      case (r_state)
        ST_FREE: begin
          if (w_accept) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            // Zero-divisor path returns the raw dividend, so keep it uncorrected.
            r_quo   <= w_div_zero ? opdata1_i : w_op1_abs;
            r_div   <= w_op2_abs;
            r_neg_q <= w_op1_neg ^ w_op2_neg;
            r_neg_r <= w_op1_neg;
          end
        end
        ST_BY_ZERO: begin
          if (!annul_i) begin
            quotient_o  <= '1;
            remainder_o <= r_quo;
            ready_o     <= DivResultReady;
          end
        end
        ST_ON: begin
          if (!annul_i) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              quotient_o  <= r_neg_q ? -w_quo_next : w_quo_next;
              remainder_o <= r_neg_r ? -w_rem_next : w_rem_next;
              ready_o     <= DivResultReady;
            end
          end
        end
        ST_END: begin
          if (annul_i || !start_i) begin
            quotient_o  <= '0;
            remainder_o <= '0;
            ready_o     <= DivResultNotReady;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed RISC-V corner cases plus random
// operands compared against an arithmetic reference model.
module tb_ex_div;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [31:0] quotient_o;
  logic [31:0] remainder_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  ex_div #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .quotient_o   (quotient_o),
    .remainder_o  (remainder_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RISC-V M-extension division semantics.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  input logic sgn,
                                  output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 32'd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  // Raise start with operands and count edges until ready_o (bounded).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       output int n);
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = sgn;
    start_i      = 1'b1;
    n = 0;
    while (!ready_o && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic end_op();
    start_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready_o); end
    checks++;
    if (quotient_o !== 32'd0) begin errors++; $display("FAIL reset_q: got %h expected 0", quotient_o); end
    checks++;
    if (remainder_o !== 32'd0) begin errors++; $display("FAIL reset_r: got %h expected 0", remainder_o); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_unsigned_basic();
    int n;
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL ready_on_start: got %b expected 0", ready_o); end
    do_op(32'd100, 32'd7, 1'b0, n);
    checks++;
    if (n != 33) begin errors++; $display("FAIL basic_latency: got %0d expected 33", n); end
    checks++;
    if (quotient_o !== 32'd14) begin errors++; $display("FAIL basic_q: got %h expected %h", quotient_o, 32'd14); end
    checks++;
    if (remainder_o !== 32'd2) begin errors++; $display("FAIL basic_r: got %h expected %h", remainder_o, 32'd2); end
    opdata1_i = 32'hDEAD_BEEF;
    opdata2_i = 32'd3;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (ready_o !== 1'b1 || quotient_o !== 32'd14 || remainder_o !== 32'd2) begin
        errors++;
        $display("FAIL basic_hold: got ready=%b q=%h r=%h expected ready=1 q=%h r=%h",
                 ready_o, quotient_o, remainder_o, 32'd14, 32'd2);
      end
    end
    end_op();
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[6];
    int n;
    v[0] = '{32'hFFFF_FFF9, 32'd2,        1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33};
    v[1] = '{32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,        33};
    v[2] = '{32'h1234_5678, 32'd0,        1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 2};
    v[3] = '{32'h1234_5678, 32'd0,        1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 2};
    v[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,        33};
    v[5] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000, 33};
    for (int i = 0; i < 6; i++) begin
      do_op(v[i].a, v[i].b, v[i].sgn, n);
      checks++;
      if (n != v[i].lat) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, n, v[i].lat); end
      checks++;
      if (quotient_o !== v[i].q) begin errors++; $display("FAIL dir%0d_q: got %h expected %h", i, quotient_o, v[i].q); end
      checks++;
      if (remainder_o !== v[i].r) begin errors++; $display("FAIL dir%0d_r: got %h expected %h", i, remainder_o, v[i].r); end
      end_op();
    end
  endtask

  task automatic test_annul();
    int seen;
    opdata1_i = 32'd1000; opdata2_i = 32'd9; signed_div_i = 1'b0; start_i = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    checks++;
    if (ready_o !== 1'b0 || quotient_o !== 32'd0 || remainder_o !== 32'd0) begin
      errors++;
      $display("FAIL annul_clear: got ready=%b q=%h r=%h expected all 0", ready_o, quotient_o, remainder_o);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready_o) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL annul_no_ready: got %0d ready cycles expected 0", seen); end
  endtask

  task automatic test_reset_midrun();
    int n;
    logic [31:0] eq, er;
    opdata1_i = 32'd5000; opdata2_i = 32'd13; signed_div_i = 1'b0; start_i = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b0 || quotient_o !== 32'd0 || remainder_o !== 32'd0) begin
      errors++;
      $display("FAIL midrun_reset: got ready=%b q=%h r=%h expected all 0", ready_o, quotient_o, remainder_o);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    ref_div(32'hFFFF_FFFF, 32'h10, 1'b0, eq, er);
    do_op(32'hFFFF_FFFF, 32'h10, 1'b0, n);
    checks++;
    if (n != 33) begin errors++; $display("FAIL after_reset_latency: got %0d expected 33", n); end
    checks++;
    if (quotient_o !== eq) begin errors++; $display("FAIL after_reset_q: got %h expected %h", quotient_o, eq); end
    checks++;
    if (remainder_o !== er) begin errors++; $display("FAIL after_reset_r: got %h expected %h", remainder_o, er); end
    end_op();
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] eq, er;
    ref_div(32'd123456, 32'd789, 1'b0, eq, er);
    do_op(32'd123456, 32'd789, 1'b0, n);
    checks++;
    if (quotient_o !== eq || remainder_o !== er) begin
      errors++;
      $display("FAIL b2b_first: got q=%h r=%h expected q=%h r=%h", quotient_o, remainder_o, eq, er);
    end
    end_op();
    checks++;
    if (ready_o !== 1'b0 || quotient_o !== 32'd0 || remainder_o !== 32'd0) begin
      errors++;
      $display("FAIL b2b_gap: got ready=%b q=%h r=%h expected all 0", ready_o, quotient_o, remainder_o);
    end
    ref_div(32'hFFFF_0000, 32'd37, 1'b1, eq, er);
    do_op(32'hFFFF_0000, 32'd37, 1'b1, n);
    checks++;
    if (n != 33) begin errors++; $display("FAIL b2b_latency: got %0d expected 33", n); end
    checks++;
    if (quotient_o !== eq || remainder_o !== er) begin
      errors++;
      $display("FAIL b2b_second: got q=%h r=%h expected q=%h r=%h", quotient_o, remainder_o, eq, er);
    end
    end_op();
  endtask

  task automatic test_random();
    int n, lat;
    logic [31:0] a, b, eq, er;
    logic sgn;
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        3:       begin a = 32'h8000_0000; b = $urandom; end
        4:       b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      ref_div(a, b, sgn, eq, er);
      lat = (b == 32'd0) ? 2 : 33;
      do_op(a, b, sgn, n);
      checks++;
      if (n != lat) begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, n, lat); end
      checks++;
      if (quotient_o !== eq || remainder_o !== er) begin
        errors++;
        $display("FAIL rand%0d_result: a=%h b=%h s=%b got q=%h r=%h expected q=%h r=%h",
                 i, a, b, sgn, quotient_o, remainder_o, eq, er);
      end
      end_op();
    end
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    annul_i = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i = 32'd0;
    opdata2_i = 32'd0;
    test_reset();
    test_unsigned_basic();
    test_directed();
    test_annul();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_div.md
# ex_div

Multi-cycle RV32M integer divider serving the execute stage. The execute stage raises `start_i` with two operands for DIV/DIVU/REM/REMU and holds `stallreq` high until this block returns `ready_o`. The block is a responder on a start/ready handshake and produces quotient and remainder together after a fixed number of iterations. Results follow RISC-V conventions, including divide-by-zero and signed overflow.

## Interface
- `XLEN`, default 32: operand and result width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start_i`  in  1  request, held high by the execute stage until `ready_o` has been seen.
- `annul_i`  in  1  abort the current operation (pipeline flush).
- `signed_div_i`  in  1  1 = DIV/REM semantics, 0 = DIVU/REMU semantics.
- `opdata1_i`  in  XLEN  dividend.
- `opdata2_i`  in  XLEN  divisor.
- `quotient_o`  out  XLEN  registered quotient.
- `remainder_o`  out  XLEN  registered remainder.
- `ready_o`  out  1  registered; results are valid while this is high.

## Operation
- **States:** FREE, BY_ZERO, ON, END.
- **Reset:** `rst` has priority over every input. On `rst`: state goes to FREE, the counter to 0, and `quotient_o`, `remainder_o` and `ready_o` to 0.
- **FREE:** on `start_i=1` and `annul_i=0`:
  - Latch both operands and `signed_div_i`.
  - If the divisor is 0, go to BY_ZERO.
  - Otherwise go to ON with counter 0.
  - If signed, latch the absolute value of each negative operand (two's complement), and record two flags: `neg_q` = the operand signs differ, `neg_r` = the dividend is negative.
- **ON:** each cycle performs one restoring step on a 2·XLEN+1-bit partial register {rem, quo}:
  - Shift the register left by 1.
  - Do a 33-bit trial subtraction of rem minus the divisor.
  - If the result is non-negative, replace rem with it and set quo[0]=1; otherwise set quo[0]=0.
  - Increment the counter.
  - On the step where counter = XLEN−1, go to END. On that same edge, write the sign-corrected results: negate the quotient if `neg_q`, negate the remainder if `neg_r`.
- **BY_ZERO:** go to END with `quotient_o` = all ones and `remainder_o` = the original, uncorrected dividend.
- **END:**
  - `ready_o`=1; results are held.
  - If `start_i`=0 at an edge, go to FREE and clear `ready_o`, `quotient_o` and `remainder_o` to 0.
  - If `start_i`=1, stay in END.
- **Annul:** `annul_i`=1 in ON, BY_ZERO or END sends the block to FREE at the next edge, with outputs cleared. `annul_i` has priority over `start_i`.
- Operand inputs are ignored outside the FREE accept edge.
- **Signed overflow** (−2^31 / −1) needs no special path. Magnitude 2^31 divided by 1 gives quotient 0x80000000 with `neg_q`=0, and remainder 0.

## Timing
- Start is accepted at edge E0.
- **Nonzero divisor:** ON covers edges E1..E32. `ready_o` is high in the cycle after E32, i.e. after 33 edges.
- **Divisor zero:** `ready_o` is high after E1, i.e. after 2 edges.
- The execute stage consumes the results in the first `ready_o` cycle. `start_i` is expected to fall on the next cycle. The minimum spacing back to the next accept is one FREE cycle.
- `ready_o` never asserts in the cycle in which `start_i` first rises.
- Outputs change only on clock edges; there are no combinational paths from inputs to outputs.

## Structure
- State encodings (FREE/BY_ZERO/ON/END, 2 bits), `DivResultReady`/`DivResultNotReady`, `DivStart`/`DivStop`, and the XLEN/`RegBus` width go in `defines.v` next to the existing ALU op/sel constants.
- Add an ALU op code for each of DIV, DIVU, REM, REMU to `defines.v`.
- No sub-module: the iteration step and sign correction are inline. The whole block is a single always block for the FSM and datapath, plus combinational trial subtraction.

## Test plan
- Unsigned 100 / 7 → q=14, r=2; `ready_o` rises exactly 33 edges after accept and stays high while `start_i` is held.
- Signed 0xFFFFFFF9 (−7) / 2 → q=0xFFFFFFFD, r=0xFFFFFFFF. Signed 7 / 0xFFFFFFFE → q=0xFFFFFFFD, r=1.
- Divide by zero: signed 0x12345678 / 0 → q=0xFFFFFFFF, r=0x12345678, ready after 2 edges. The unsigned variant gives identical values.
- Overflow: signed 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0. The same operands unsigned → q=0, r=0x80000000.
- `annul_i` pulsed at E10 → FREE next edge, `ready_o` never rises. `rst` asserted at E20 of a second run → all outputs 0 next edge. A following start of 0xFFFFFFFF / 0x10 (unsigned) completes correctly with q=0x0FFFFFFF, r=0xF.
- Back-to-back: drop `start_i` for one cycle after ready, then restart with new operands → the second result is correct, and the outputs read 0 during the intervening FREE cycle.
